// File: rtl/cd_pkg.sv
// rtl/cd_pkg.sv - shared state encoding and seven-segment patterns for countdown_display
// Purpose: one place for the controller state enum and the BCD-to-segment table.
// Contents: cd_state_t, SEG_0..SEG_9 (bits [6:0] = g..a, active-low), bcd_to_seg().
package cd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RUN     = 2'd1,
      ST_PAUSE   = 2'd2,
      ST_EXPIRED = 2'd3
   } cd_state_t;

   localparam logic [6:0] SEG_0 = 7'b1000000;
   localparam logic [6:0] SEG_1 = 7'b1111001;
   localparam logic [6:0] SEG_2 = 7'b0100100;
   localparam logic [6:0] SEG_3 = 7'b0110000;
   localparam logic [6:0] SEG_4 = 7'b0011001;
   localparam logic [6:0] SEG_5 = 7'b0010010;
   localparam logic [6:0] SEG_6 = 7'b0000010;
   localparam logic [6:0] SEG_7 = 7'b1111000;
   localparam logic [6:0] SEG_8 = 7'b0000000;
   localparam logic [6:0] SEG_9 = 7'b0010000;

   // Non-BCD codes cannot reach the decoder (loads saturate to 9); dark is the safe fallback.
   function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// rtl/seg7_decode.sv - combinational single-digit BCD to seven-segment decoder
// Purpose: maps one BCD digit to active-low segments plus decimal point.
// Ports:
//   i_bcd   in  4  BCD digit
//   i_blank in  1  1 forces the whole digit dark (8'hFF), decimal point included
//   i_dp    in  1  1 lights the decimal point
//   o_hex   out 8  [6:0] segments g..a active-low, [7] decimal point active-low
module seg7_decode (
   input  logic [3:0] i_bcd,
   input  logic       i_blank,
   input  logic       i_dp,
   output logic [7:0] o_hex
);
   import cd_pkg::*;

   always_comb begin
      o_hex = 8'hFF;
      if (!i_blank) begin
         o_hex = {~i_dp, bcd_to_seg(i_bcd)};
      end
   end

endmodule

// File: rtl/countdown_display.sv
// rtl/countdown_display.sv - BCD countdown timer driving multiplexed-free seven-segment outputs
// Purpose: loadable BCD down-counter with run/pause control, expiry flag and blinking display.
// Ports:
//   clk      in  1          system clock
//   rst_n    in  1          synchronous active-low reset
//   load     in  1          captures load_val (digits >9 stored as 9), returns to idle
//   load_val in  4*DIGITS   BCD value, digit i in [4i+3:4i]
//   start    in  1          begin/resume counting when count != 0
//   pause    in  1          suspend counting
//   count    out 4*DIGITS   current BCD value
//   done     out 1          high while expired
//   hex      out 8*DIGITS   digit i in [8i+7:8i], active-low segments and decimal point
module countdown_display #(
   parameter int DIGITS    = 2,
   parameter int TICK_DIV  = 50_000_000,
   parameter int BLINK_DIV = 12_500_000,
   parameter int DP_POS    = 0,
   parameter int LZ_BLANK  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
   input  logic                  start,
   input  logic                  pause,
   output logic [4*DIGITS-1:0]   count,
   output logic                  done,
   output logic [8*DIGITS-1:0]   hex
);
   import cd_pkg::*;

   localparam int PW = (TICK_DIV  > 1) ? $clog2(TICK_DIV)  : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);

   function automatic logic [4*DIGITS-1:0] bcd_sat(input logic [4*DIGITS-1:0] v);
      logic [4*DIGITS-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
      end
      return r;
   endfunction

   // Ripple borrow from digit 0 upward; zero stays zero.
   function automatic logic [4*DIGITS-1:0] bcd_dec(input logic [4*DIGITS-1:0] v);
      logic [4*DIGITS-1:0] r;
      logic                borrow;
      r      = v;
      borrow = (v != '0);
      for (int i = 0; i < DIGITS; i++) begin
         if (borrow) begin
            if (v[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = 4'd9;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   cd_state_t             r_state;
   cd_state_t             w_state_next;
   logic [4*DIGITS-1:0]   r_count;
   logic [PW-1:0]         r_presc;
   logic [BW-1:0]         r_blink_cnt;
   logic                  r_visible;
   logic [8*DIGITS-1:0]   r_hex;

   logic [4*DIGITS-1:0]   w_count_dec;
   logic                  w_count_nz;
   logic                  w_tick;
   logic                  w_run_step;
   logic [4*DIGITS-1:0]   w_disp_val;
   logic                  w_show;
   logic [DIGITS-1:0]     w_blank;
   logic [DIGITS-1:0]     w_dp;
   logic [8*DIGITS-1:0]   w_hex_next;

   assign w_count_dec = bcd_dec(r_count);
   assign w_count_nz  = (r_count != '0);
   assign w_tick      = (r_presc == PRESC_MAX);
   assign w_run_step  = (r_state == ST_RUN) && !pause && !load;

   always_comb begin
      w_state_next = r_state;
      if (load) begin
         w_state_next = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE, ST_PAUSE: begin
               // pause outranks start, so a simultaneous start is dropped
               if (!pause && start && w_count_nz) w_state_next = ST_RUN;
            end
            ST_RUN: begin
               if (pause) begin
                  w_state_next = ST_PAUSE;
               end else if (w_tick && (w_count_dec == '0)) begin
                  w_state_next = ST_EXPIRED;
               end
            end
            default: w_state_next = r_state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_presc     <= '0;
         r_blink_cnt <= '0;
         r_visible   <= 1'b1;
      end else begin
         r_state <= w_state_next;

         if (load) begin
            r_count <= bcd_sat(load_val);
            r_presc <= '0;
         end else if (w_run_step) begin
            if (w_tick) begin
               r_presc <= '0;
               r_count <= w_count_dec;
            end else begin
               r_presc <= r_presc + PW'(1);
            end
         end

         // Blink phase restarts visible on every entry into expiry.
         if ((r_state == ST_EXPIRED) && (w_state_next == ST_EXPIRED)) begin
            if (r_blink_cnt == BLINK_MAX) begin
               r_blink_cnt <= '0;
               r_visible   <= ~r_visible;
            end else begin
               r_blink_cnt <= r_blink_cnt + BW'(1);
            end
         end else begin
            r_blink_cnt <= '0;
            r_visible   <= 1'b1;
         end
      end
      // Decoder inputs already account for reset, so hex lands on the zero image.
      r_hex <= w_hex_next;
   end

   assign w_disp_val = rst_n ? r_count : '0;
   assign w_show     = !rst_n || (r_state != ST_EXPIRED) || r_visible;

   always_comb begin
      logic zero_above;
      w_blank    = '0;
      w_dp       = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zero_above = zero_above && (w_disp_val[4*i +: 4] == 4'd0);
         w_blank[i] = !w_show ||
                      ((LZ_BLANK != 0) && zero_above && (i != 0) && (i != DP_POS));
         w_dp[i]    = (i == DP_POS);
      end
   end

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_digit
         seg7_decode u_seg (
            .i_bcd   (w_disp_val[4*g +: 4]),
            .i_blank (w_blank[g]),
            .i_dp    (w_dp[g]),
            .o_hex   (w_hex_next[8*g +: 8])
         );
      end
   endgenerate

   assign count = r_count;
   assign done  = (r_state == ST_EXPIRED);
   assign hex   = r_hex;

endmodule

// File: doc/countdown_display.md
COUNTDOWN_DISPLAY -- requirements
Module: countdown_display

Interface
REQ-001 SHALL have parameter DIGITS, default 2: number of BCD digits and seven-segment outputs (1..8).
REQ-002 SHALL have parameter TICK_DIV, default 50_000_000: clk cycles per countdown decrement (>=2).
REQ-003 SHALL have parameter BLINK_DIV, default 12_500_000: clk cycles per blink half-period in EXPIRED (>=2).
REQ-004 SHALL have parameter DP_POS, default 0: digit index whose decimal point is lit; -1 means no decimal point.
REQ-005 SHALL have parameter LZ_BLANK, default 1: 1 blanks leading zeros; the least significant digit is never blanked.
REQ-006 clk  input  1  system clock; single clock domain. Reset is synchronous and active-low.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 load  input  1  one-cycle pulse; captures load_val.
REQ-009 load_val  input  4*DIGITS  BCD value; digit i in bits [4i+3:4i].
REQ-010 start  input  1  level or pulse; begins/resumes counting.
REQ-011 pause  input  1  level or pulse; suspends counting.
REQ-012 count  output  4*DIGITS  current BCD value, registered.
REQ-013 done  output  1  high while in EXPIRED.
REQ-014 hex  output  8*DIGITS  digit i in bits [8i+7:8i]; bits [6:0] segments g..a active-low, bit 7 decimal point active-low.

Function
REQ-015 SHALL implement states IDLE, RUN, PAUSE, EXPIRED.
REQ-016 Input priority SHALL be load > pause > start when asserted in the same cycle.
REQ-017 load in any state SHALL write load_val to count next cycle, clear the prescaler, and enter IDLE; any loaded digit >9 SHALL be stored as 9.
REQ-018 start in IDLE or PAUSE SHALL enter RUN if count != 0; if count == 0 it SHALL be ignored.
REQ-019 pause in RUN SHALL enter PAUSE; the prescaler and count SHALL hold.
REQ-020 In RUN the prescaler SHALL count 0..TICK_DIV-1; on reaching TICK_DIV-1 it SHALL wrap to 0 and count SHALL decrement by 1 with BCD borrow across all digits.
REQ-021 On the decrement that makes count 0, the next state SHALL be EXPIRED, and done SHALL rise in the same cycle that count reads 0.
REQ-022 count SHALL never wrap below 0.
REQ-023 In EXPIRED, start and pause SHALL be ignored; only load or reset exits.
REQ-024 In EXPIRED a blink counter SHALL toggle visibility every BLINK_DIV cycles, starting visible. When invisible, hex SHALL be all 1s, including decimal points.
REQ-025 hex SHALL be registered and SHALL reflect count exactly one cycle after count changes.
REQ-026 Segment patterns for 0..9 SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-027 A blanked digit SHALL output 8'hFF, with the decimal point off even at DP_POS.
REQ-028 With LZ_BLANK=1, digit i SHALL be blanked when digit i and all higher digits are 0, and i is neither 0 nor DP_POS.

Reset
REQ-029 While rst_n=0 at a clk edge: state SHALL be IDLE; count, prescaler and blink counter SHALL be 0; done SHALL be 0.
REQ-030 hex SHALL then show the value 0 per REQ-027/028. For DIGITS=2, DP_POS=0 this is hex=16'hFF40.
REQ-031 Reset mid-RUN SHALL discard count; no done pulse SHALL occur.

Structure
REQ-032 A shared package cd_pkg SHALL hold the state enum and the ten segment-pattern constants.
REQ-033 A combinational sub-module seg7_decode (4-bit BCD, blank, dp in -> 8-bit hex out) SHALL be instantiated once per digit with a generate loop.

Verification (DIGITS=2, TICK_DIV=4, BLINK_DIV=3, DP_POS=0, LZ_BLANK=1)
REQ-034 Load 8'h12, then start -> count steps 12,11,10,09,... every 4 cycles. At 09, hex[15:8]=FF and hex[7:0]=10.
REQ-035 Count 8'h10, one tick -> count=09 (borrow across digits). Count 8'h01, one tick -> count=00, done=1 the same cycle, state EXPIRED.
REQ-036 In EXPIRED -> hex alternates FF40 (3 cycles) and FFFF (3 cycles). Start and pause have no effect.
REQ-037 In RUN, assert pause for 10 cycles then start -> count is unchanged during the pause, and the next decrement occurs after the remaining prescaler cycles.
REQ-038 load, pause and start asserted together with load_val=8'hA5 -> count=95, state IDLE.
REQ-039 rst_n=0 for one cycle mid-RUN with count=07 -> count=00, done=0, hex=FF40, state IDLE.
